// File: rtl/pipe_pkg.sv
// Shared definitions for the fetch stage and its IF/ID pipeline register.
// Contents:
//   fetch_state_e : fetch FSM states (BOOT, RUN, WAIT)
//   pc_sel_e      : next-PC mux select used by pc_reg
//   ifid_t        : IF/ID pipeline word {instr, pc4, valid}
//   PC_STEP       : PC increment per sequential instruction
package pipe_pkg;

    localparam int XLEN    = 32;
    localparam int PC_STEP = 4;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2
    } fetch_state_e;

    typedef enum logic [1:0] {
        PC_SEL_HOLD   = 2'd0,
        PC_SEL_INC    = 2'd1,
        PC_SEL_TARGET = 2'd2
    } pc_sel_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc4;
        logic            valid;
    } ifid_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter register with its next-PC mux.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset (loads RESET_PC)
//   sel        : hold / increment by PC_STEP / load target
//   target     : redirect address
//   pc         : current PC
module pc_reg
    import pipe_pkg::*;
#(
    parameter int              ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  pc_sel_e           sel,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_next;

    always_comb begin
        pc_next = pc;
        unique case (sel)
            PC_SEL_INC:    pc_next = pc + ADDR_W'(PC_STEP);  // wraps at 2^ADDR_W
            PC_SEL_TARGET: pc_next = target;
            default:       pc_next = pc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, requests instruction memory, and
// registers the IF/ID word consumed by decode. Applies decode's branch
// redirects (PCSelect/BranchDir), honours stalls, counts fetches and flushes.
// Ports:
//   clk, rst_n              : clock, synchronous active-low reset
//   stall                   : hold PC and IF/ID register
//   PCSelect, BranchDir     : redirect request and PC-relative offset from decode
//   imem_req/addr/ready/rdata : instruction memory interface
//   id_instr/id_pc4/id_valid  : IF/ID pipeline word
//   fetch_cnt, flush_cnt    : performance counters (wrap at 2^32)
//   state                   : fetch FSM state, for observation
//
// Memory handshake: a fetch completes in the cycle where imem_req and
// imem_ready are both high; imem_rdata is valid in that same cycle. imem_req
// stays high with imem_addr unchanged until accepted, except that a redirect
// changes the address. Whether an accepted word is captured is decided by
// redirect/stall priority; an uncaptured word is simply re-requested.
module fetch_unit
    import pipe_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               PCSelect,
    input  logic [ADDR_W-1:0]  BranchDir,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] id_instr,
    output logic [ADDR_W-1:0]  id_pc4,
    output logic               id_valid,
    output logic [31:0]        fetch_cnt,
    output logic [31:0]        flush_cnt,
    output fetch_state_e       state
);

    fetch_state_e      state_q, state_d;
    ifid_t             ifid;
    pc_sel_e           pc_sel;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] target;
    logic              redir;
    logic              accept;

    // A redirect is only meaningful when the word in decode is real; this
    // also makes a repeated PCSelect right after a flush harmless.
    assign redir  = PCSelect & ifid.valid;
    assign target = ifid.pc4 + BranchDir;
    assign accept = imem_req & imem_ready & ~stall & ~redir;

    always_comb begin
        pc_sel = PC_SEL_HOLD;
        if (redir) begin
            pc_sel = PC_SEL_TARGET;
        end else if (accept) begin
            pc_sel = PC_SEL_INC;
        end
    end

    pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .sel    (pc_sel),
        .target (target),
        .pc     (pc)
    );

    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        unique case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                imem_req = 1'b1;
                if (!redir && !imem_ready) state_d = WAIT;
            end
            WAIT: begin
                imem_req = 1'b1;
                if (redir || imem_ready) state_d = RUN;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= BOOT;
            ifid      <= '0;
            fetch_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            state_q <= state_d;
            if (redir) begin
                // Wrong-path word is dropped; anything returned now is discarded.
                ifid.valid <= 1'b0;
                flush_cnt  <= flush_cnt + 32'd1;
            end else if (!stall) begin
                if (accept) begin
                    ifid.instr <= imem_rdata;
                    ifid.pc4   <= pc + ADDR_W'(PC_STEP);
                    ifid.valid <= 1'b1;
                    fetch_cnt  <= fetch_cnt + 32'd1;
                end else begin
                    ifid.valid <= 1'b0;
                end
            end
        end
    end

    assign imem_addr = pc;
    assign id_instr  = ifid.instr;
    assign id_pc4    = ifid.pc4;
    assign id_valid  = ifid.valid;
    assign state     = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit. Instance u_dut (RESET_PC=0) is tracked cycle by cycle
// by a behavioural model; instance u_dut_b (RESET_PC=32'hFFFF_FFFC) covers
// address wrap and reset during a pending fetch with directed expectations.
// The instruction ROM returns address ^ rom_key.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n, stall, pcsel, ready;
    logic [31:0] bdir, rdata, addr, id_instr, id_pc4, fetch_cnt, flush_cnt;
    logic        req, id_valid;
    pipe_pkg::fetch_state_e state;

    logic        rst_n_b, stall_b, pcsel_b, ready_b;
    logic [31:0] bdir_b, rdata_b, addr_b, id_instr_b, id_pc4_b, fetch_cnt_b, flush_cnt_b;
    logic        req_b, id_valid_b;
    pipe_pkg::fetch_state_e state_b;

    logic [31:0] rom_key;

    // Reference model of instance u_dut
    logic        m_boot, m_iv, m_fetched;
    logic [31:0] m_pc, m_instr, m_pc4, m_fc, m_flc;
    logic [31:0] exp_q[$];

    int n_cmp, n_fail;

    assign rdata   = addr ^ rom_key;
    assign rdata_b = addr_b ^ rom_key;

    fetch_unit #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .PCSelect(pcsel), .BranchDir(bdir),
        .imem_req(req), .imem_addr(addr), .imem_ready(ready), .imem_rdata(rdata),
        .id_instr(id_instr), .id_pc4(id_pc4), .id_valid(id_valid),
        .fetch_cnt(fetch_cnt), .flush_cnt(flush_cnt), .state(state)
    );

    fetch_unit #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'hFFFF_FFFC)) u_dut_b (
        .clk(clk), .rst_n(rst_n_b), .stall(stall_b), .PCSelect(pcsel_b), .BranchDir(bdir_b),
        .imem_req(req_b), .imem_addr(addr_b), .imem_ready(ready_b), .imem_rdata(rdata_b),
        .id_instr(id_instr_b), .id_pc4(id_pc4_b), .id_valid(id_valid_b),
        .fetch_cnt(fetch_cnt_b), .flush_cnt(flush_cnt_b), .state(state_b)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [161:0] obs_vec();
        return {req, addr, id_valid, id_valid ? id_instr : 32'd0,
                id_valid ? id_pc4 : 32'd0, fetch_cnt, flush_cnt};
    endfunction

    function automatic logic [161:0] exp_vec();
        return {~m_boot, m_pc, m_iv, m_iv ? m_instr : 32'd0,
                m_iv ? m_pc4 : 32'd0, m_fc, m_flc};
    endfunction

    // Advance the model by one cycle using the inputs currently driven, then
    // let the clock edge happen and settle 1 time unit past it.
    task automatic tick();
        logic redir;
        redir     = pcsel & m_iv;
        m_fetched = 1'b0;
        if (!rst_n) begin
            m_pc = 32'h0; m_boot = 1'b1; m_iv = 1'b0; m_instr = 32'h0;
            m_pc4 = 32'h0; m_fc = 32'h0; m_flc = 32'h0;
            exp_q.delete();
        end else begin
            if (redir) begin
                m_pc  = m_pc4 + bdir;
                m_iv  = 1'b0;
                m_flc = m_flc + 1;
            end else if (stall) begin
                // everything holds
            end else if (!m_boot && ready) begin
                m_instr = m_pc ^ rom_key;
                m_pc4   = m_pc + 4;
                m_pc    = m_pc + 4;
                m_iv    = 1'b1;
                m_fc    = m_fc + 1;
                exp_q.push_back(m_instr);
                m_fetched = 1'b1;
            end else begin
                m_iv = 1'b0;
            end
            m_boot = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; stall = 1'b0; pcsel = 1'b0; ready = 1'b1;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        n_cmp++; if (obs_vec() !== exp_vec()) begin n_fail++;
            $display("FAIL reset_vec: got %h want %h", obs_vec(), exp_vec()); end
        n_cmp++; if (req !== 1'b0 || id_valid !== 1'b0) begin n_fail++;
            $display("FAIL reset_req_valid: got req=%b valid=%b want 0 0", req, id_valid); end
        n_cmp++; if (fetch_cnt !== 32'd0 || flush_cnt !== 32'd0) begin n_fail++;
            $display("FAIL reset_counters: got %0d %0d want 0 0", fetch_cnt, flush_cnt); end
        n_cmp++; if (state !== pipe_pkg::BOOT) begin n_fail++;
            $display("FAIL reset_state: got %0d want BOOT", state); end
    endtask

    task automatic test_sequential();
        logic [31:0] want;
        do_reset();
        n_cmp++; if (req !== 1'b0) begin n_fail++;
            $display("FAIL boot_req: got %b want 0", req); end
        tick();
        n_cmp++; if (req !== 1'b1 || addr !== 32'h0) begin n_fail++;
            $display("FAIL first_req: got req=%b addr=%h want 1 0", req, addr); end
        for (int i = 0; i < 3; i++) begin
            tick();
            want = 32'(i) * 4;
            n_cmp++; if (id_valid !== 1'b1 || id_instr !== want || id_pc4 !== want + 4) begin n_fail++;
                $display("FAIL seq_word%0d: got v=%b i=%h p=%h want 1 %h %h",
                         i, id_valid, id_instr, id_pc4, want, want + 4); end
            n_cmp++; if (obs_vec() !== exp_vec()) begin n_fail++;
                $display("FAIL seq_vec: got %h want %h", obs_vec(), exp_vec()); end
        end
        n_cmp++; if (fetch_cnt !== 32'd3) begin n_fail++;
            $display("FAIL seq_fetch_cnt: got %0d want 3", fetch_cnt); end
    endtask

    task automatic test_redirect();
        do_reset();
        tick(); tick(); tick();
        n_cmp++; if (id_pc4 !== 32'h8 || id_valid !== 1'b1) begin n_fail++;
            $display("FAIL redir_setup: got pc4=%h v=%b want 8 1", id_pc4, id_valid); end
        pcsel = 1'b1; bdir = 32'h10;
        tick();
        pcsel = 1'b0;
        n_cmp++; if (addr !== 32'h18 || id_valid !== 1'b0 || flush_cnt !== 32'd1) begin n_fail++;
            $display("FAIL redir_target: got a=%h v=%b fl=%0d want 18 0 1", addr, id_valid, flush_cnt); end
        tick();
        n_cmp++; if (id_valid !== 1'b1 || id_instr !== 32'h18) begin n_fail++;
            $display("FAIL redir_no_wrong_path: got v=%b i=%h want 1 18", id_valid, id_instr); end
        n_cmp++; if (obs_vec() !== exp_vec()) begin n_fail++;
            $display("FAIL redir_vec: got %h want %h", obs_vec(), exp_vec()); end
    endtask

    task automatic test_stall();
        logic [31:0] s_instr, s_pc4, s_pc, s_fc;
        s_instr = m_instr; s_pc4 = m_pc4; s_pc = m_pc; s_fc = m_fc;
        stall = 1'b1; ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (id_instr !== s_instr || id_pc4 !== s_pc4 || id_valid !== 1'b1
                         || addr !== s_pc || fetch_cnt !== s_fc) begin n_fail++;
                $display("FAIL stall_hold: got i=%h p=%h v=%b a=%h fc=%0d want %h %h 1 %h %0d",
                         id_instr, id_pc4, id_valid, addr, fetch_cnt, s_instr, s_pc4, s_pc, s_fc); end
        end
        stall = 1'b0;
        tick();
        n_cmp++; if (id_instr !== (s_pc ^ rom_key) || id_pc4 !== s_pc + 4 || fetch_cnt !== s_fc + 1) begin n_fail++;
            $display("FAIL stall_resume: got i=%h p=%h fc=%0d want %h %h %0d",
                     id_instr, id_pc4, fetch_cnt, s_pc ^ rom_key, s_pc + 4, s_fc + 1); end
    endtask

    task automatic test_wait();
        logic [31:0] s_pc;
        s_pc = m_pc;
        ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++; if (state !== pipe_pkg::WAIT || addr !== s_pc || req !== 1'b1 || id_valid !== 1'b0) begin n_fail++;
                $display("FAIL wait_hold: got st=%0d a=%h r=%b v=%b want WAIT %h 1 0",
                         state, addr, req, id_valid, s_pc); end
        end
        ready = 1'b1;
        tick();
        n_cmp++; if (id_valid !== 1'b1 || id_instr !== (s_pc ^ rom_key) || state !== pipe_pkg::RUN) begin n_fail++;
            $display("FAIL wait_capture: got v=%b i=%h st=%0d want 1 %h RUN", id_valid, id_instr, state, s_pc ^ rom_key); end
        n_cmp++; if (obs_vec() !== exp_vec()) begin n_fail++;
            $display("FAIL wait_vec: got %h want %h", obs_vec(), exp_vec()); end
    endtask

    task automatic test_stall_redirect_back_to_back();
        logic [31:0] s_t, s_fl;
        s_t  = m_pc4 + 32'h40;
        s_fl = m_flc;
        stall = 1'b1; pcsel = 1'b1; bdir = 32'h40;
        tick();
        n_cmp++; if (addr !== s_t || flush_cnt !== s_fl + 1 || id_valid !== 1'b0) begin n_fail++;
            $display("FAIL stall_vs_redir: got a=%h fl=%0d v=%b want %h %0d 0", addr, flush_cnt, id_valid, s_t, s_fl + 1); end
        // PCSelect still high but the IF/ID word is now a bubble: no effect
        stall = 1'b0;
        tick();
        pcsel = 1'b0;
        n_cmp++; if (flush_cnt !== s_fl + 1 || addr !== s_t + 4 || id_valid !== 1'b1 || id_instr !== (s_t ^ rom_key)) begin n_fail++;
            $display("FAIL back_to_back: got fl=%0d a=%h v=%b i=%h want %0d %h 1 %h",
                     flush_cnt, addr, id_valid, id_instr, s_fl + 1, s_t + 4, s_t ^ rom_key); end
    endtask

    task automatic test_random();
        logic [31:0] want;
        rom_key = $urandom();
        exp_q.delete();
        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            stall = ($urandom_range(0, 3) == 0);
            ready = ($urandom_range(0, 9) < 7);
            pcsel = ($urandom_range(0, 4) == 0);
            bdir  = 32'($urandom_range(0, 127)) * 4 - 32'd256;
            tick();
            n_cmp++; if (obs_vec() !== exp_vec()) begin n_fail++;
                $display("FAIL rand_vec[%0d]: got %h want %h", i, obs_vec(), exp_vec()); end
            if (m_fetched) begin
                want = exp_q.pop_front();
                n_cmp++; if (id_instr !== want) begin n_fail++;
                    $display("FAIL rand_word[%0d]: got %h want %h", i, id_instr, want); end
            end
        end
        rst_n = 1'b1; stall = 1'b0; pcsel = 1'b0; ready = 1'b1; rom_key = 32'h0;
    endtask

    task automatic test_wrap();
        n_cmp++; if (addr_b !== 32'hFFFF_FFFC || req_b !== 1'b0) begin n_fail++;
            $display("FAIL wrap_reset_pc: got a=%h r=%b want fffffffc 0", addr_b, req_b); end
        rst_n_b = 1'b1; ready_b = 1'b1;
        tick();
        tick();
        n_cmp++; if (addr_b !== 32'h0 || id_pc4_b !== 32'h0 || id_instr_b !== 32'hFFFF_FFFC) begin n_fail++;
            $display("FAIL wrap_pc4: got a=%h p=%h i=%h want 0 0 fffffffc", addr_b, id_pc4_b, id_instr_b); end
        pcsel_b = 1'b1; bdir_b = 32'hFFFF_FFEC;
        tick();
        pcsel_b = 1'b0;
        tick();
        n_cmp++; if (id_pc4_b !== 32'hFFFF_FFF0 || id_valid_b !== 1'b1) begin n_fail++;
            $display("FAIL wrap_setup: got p=%h v=%b want fffffff0 1", id_pc4_b, id_valid_b); end
        pcsel_b = 1'b1; bdir_b = 32'h20;
        tick();
        pcsel_b = 1'b0; ready_b = 1'b0;
        n_cmp++; if (addr_b !== 32'h10 || flush_cnt_b !== 32'd2) begin n_fail++;
            $display("FAIL wrap_target: got a=%h fl=%0d want 10 2", addr_b, flush_cnt_b); end
        tick();
        tick();
        n_cmp++; if (state_b !== pipe_pkg::WAIT || fetch_cnt_b !== 32'd2) begin n_fail++;
            $display("FAIL wrap_wait: got st=%0d fc=%0d want WAIT 2", state_b, fetch_cnt_b); end
        rst_n_b = 1'b0; ready_b = 1'b1;
        tick();
        n_cmp++; if (addr_b !== 32'hFFFF_FFFC || fetch_cnt_b !== 32'd0 || flush_cnt_b !== 32'd0
                     || id_valid_b !== 1'b0 || req_b !== 1'b0) begin n_fail++;
            $display("FAIL wrap_reset_mid_wait: got a=%h fc=%0d fl=%0d v=%b r=%b want fffffffc 0 0 0 0",
                     addr_b, fetch_cnt_b, flush_cnt_b, id_valid_b, req_b); end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        rst_n = 1'b0; stall = 1'b0; pcsel = 1'b0; bdir = 32'h0; ready = 1'b1; rom_key = 32'h0;
        rst_n_b = 1'b0; stall_b = 1'b0; pcsel_b = 1'b0; bdir_b = 32'h0; ready_b = 1'b1;
        m_boot = 1'b1; m_iv = 1'b0; m_fetched = 1'b0; m_pc = 32'h0; m_instr = 32'h0;
        m_pc4 = 32'h0; m_fc = 32'h0; m_flc = 32'h0;
        #1;
        test_reset();
        test_sequential();
        test_redirect();
        test_stall();
        test_wait();
        test_stall_redirect_back_to_back();
        test_random();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
